// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// Bus and dispatch-handshake bundle between the CPU
// and the interrupt controller.
interface gb_cpu_interrupt_ctrl_if;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        write_interrupt_vector;
    logic        clear_interrupt_flag;
    logic        interrupt_queued;
    logic [7:0]  int_vector;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        output write_interrupt_vector, clear_interrupt_flag,
        input  rd_data, rd_hit, interrupt_queued, int_vector
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  write_interrupt_vector, clear_interrupt_flag,
        output rd_data, rd_hit, interrupt_queued, int_vector
    );
endinterface

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, IME
// state machine with EI delay, and dispatch responder.
module gb_cpu_interrupt_ctrl #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF,
    parameter int          NUM_IRQ = 5
) (
    input  logic               clk,
    input  logic               reset,
    gb_cpu_interrupt_ctrl_if.slave bus,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               last_m_cycle,
    input  logic               enable_interrupts,
    input  logic               reti_enable,
    input  logic               disable_interrupts,
    output logic               ime,
    output logic               halt_wake,
    output logic [NUM_IRQ-1:0] if_reg,
    output logic [7:0]         ie_reg
);

    localparam int IDX_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        IME_OFF,
        IME_ARMED,
        IME_ON
    } ime_state_t;

    ime_state_t         state_q, state_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q;
    logic [7:0]         vec_q;
    logic [IDX_W-1:0]   idx_q, prio_idx;
    logic               idx_valid_q;
    logic [NUM_IRQ-1:0] pending;
    logic               if_wr, ie_wr;

    assign pending = if_q & ie_q[NUM_IRQ-1:0];
    assign if_wr   = bus.wr_en && (bus.wr_addr == IF_ADDR);
    assign ie_wr   = bus.wr_en && (bus.wr_addr == IE_ADDR);

    // Lowest set bit wins: scan downward so bit 0 overwrites last.
    always_comb begin
        prio_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) prio_idx = IDX_W'(i);
        end
    end

    always_comb begin
        if_d = if_wr ? bus.wr_data[NUM_IRQ-1:0] : if_q;
        if (bus.clear_interrupt_flag && idx_valid_q) begin
            if_d[idx_q] = 1'b0;
        end
        if_d = if_d | irq_req;
    end

    always_comb begin
        state_d = state_q;
        if (disable_interrupts) begin
            state_d = IME_OFF;
        end else if (bus.clear_interrupt_flag) begin
            state_d = IME_OFF;
        end else if (reti_enable) begin
            state_d = IME_ON;
        end else if (enable_interrupts) begin
            if (state_q != IME_ON) state_d = IME_ARMED;
        end else if (state_q == IME_ARMED && last_m_cycle) begin
            state_d = IME_ON;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IME_OFF;
            if_q        <= '0;
            ie_q        <= 8'h00;
            vec_q       <= 8'h00;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if_q    <= if_d;
            if (ie_wr) ie_q <= bus.wr_data;
            if (bus.write_interrupt_vector) begin
                idx_q       <= prio_idx;
                idx_valid_q <= |pending;
                vec_q       <= (|pending)
                             ? 8'h40 + (8'(prio_idx) << 3)
                             : 8'h00;
            end else if (bus.clear_interrupt_flag) begin
                idx_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_data = 8'hFF;
        bus.rd_hit  = 1'b0;
        if (bus.rd_addr == IF_ADDR) begin
            bus.rd_data = {{(8 - NUM_IRQ){1'b1}}, if_q};
            bus.rd_hit  = 1'b1;
        end else if (bus.rd_addr == IE_ADDR) begin
            bus.rd_data = ie_q;
            bus.rd_hit  = 1'b1;
        end
    end

    assign ime                  = (state_q == IME_ON);
    assign halt_wake            = |pending;
    assign bus.interrupt_queued = ime && (|pending);
    assign bus.int_vector       = vec_q;
    assign if_reg               = if_q;
    assign ie_reg               = ie_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed bench for gb_cpu_interrupt_ctrl: IF/IE access,
// EI delay, dispatch, ghost dispatch and reset behaviour.
module tb_gb_cpu_interrupt_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] irq_req;
    logic       last_m_cycle, enable_interrupts;
    logic       reti_enable, disable_interrupts;
    logic       ime, halt_wake;
    logic [4:0] if_reg;
    logic [7:0] ie_reg;
    int         tests = 0;
    int         fails = 0;

    gb_cpu_interrupt_ctrl_if bus_if ();

    gb_cpu_interrupt_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus_if.slave),
        .irq_req            (irq_req),
        .last_m_cycle       (last_m_cycle),
        .enable_interrupts  (enable_interrupts),
        .reti_enable        (reti_enable),
        .disable_interrupts (disable_interrupts),
        .ime                (ime),
        .halt_wake          (halt_wake),
        .if_reg             (if_reg),
        .ie_reg             (ie_reg)
    );

    always #5 clk = ~clk;

    task automatic idle();
        irq_req = 5'b0;
        last_m_cycle = 1'b0;
        enable_interrupts = 1'b0;
        reti_enable = 1'b0;
        disable_interrupts = 1'b0;
        bus_if.wr_en = 1'b0;
        bus_if.wr_addr = 16'h0000;
        bus_if.wr_data = 8'h00;
        bus_if.write_interrupt_vector = 1'b0;
        bus_if.clear_interrupt_flag = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_if.wr_en = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        bus_if.rd_addr = 16'hFF0F;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        tests++;
        if ({if_reg, ie_reg, ime} !== 14'h0) begin
            fails++;
            $display("FAIL reset_regs: if=%h ie=%h ime=%b want 0", if_reg, ie_reg, ime);
        end
        tests++;
        if (bus_if.int_vector !== 8'h00 || bus_if.interrupt_queued !== 1'b0) begin
            fails++;
            $display("FAIL reset_vec: vec=%h q=%b want 00/0", bus_if.int_vector, bus_if.interrupt_queued);
        end
        tests++;
        if (bus_if.rd_data !== 8'hE0 || bus_if.rd_hit !== 1'b1) begin
            fails++;
            $display("FAIL reset_rd_if: rd=%h hit=%b want E0/1", bus_if.rd_data, bus_if.rd_hit);
        end
        bus_if.rd_addr = 16'h1234;
        #1;
        tests++;
        if (bus_if.rd_data !== 8'hFF || bus_if.rd_hit !== 1'b0) begin
            fails++;
            $display("FAIL rd_miss: rd=%h hit=%b want FF/0", bus_if.rd_data, bus_if.rd_hit);
        end
    endtask

    task automatic test_irq_set();
        bus_write(16'hFFFF, 8'h01);
        bus_if.rd_addr = 16'hFFFF;
        #1;
        tests++;
        if (bus_if.rd_data !== 8'h01 || ie_reg !== 8'h01) begin
            fails++;
            $display("FAIL ie_write: rd=%h ie=%h want 01", bus_if.rd_data, ie_reg);
        end
        irq_req = 5'b00001;
        tick();
        bus_if.rd_addr = 16'hFF0F;
        #1;
        tests++;
        if (if_reg !== 5'h01 || halt_wake !== 1'b1 || bus_if.interrupt_queued !== 1'b0) begin
            fails++;
            $display("FAIL irq_set: if=%h wake=%b q=%b want 01/1/0", if_reg, halt_wake, bus_if.interrupt_queued);
        end
        tests++;
        if (bus_if.rd_data !== 8'hE1) begin
            fails++;
            $display("FAIL rd_if: got %h want E1", bus_if.rd_data);
        end
    endtask

    task automatic test_ei_delay();
        enable_interrupts = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b0 || bus_if.interrupt_queued !== 1'b0) begin
            fails++;
            $display("FAIL ei_edge: ime=%b q=%b want 0/0", ime, bus_if.interrupt_queued);
        end
        last_m_cycle = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b1 || bus_if.interrupt_queued !== 1'b1) begin
            fails++;
            $display("FAIL ei_delay: ime=%b q=%b want 1/1", ime, bus_if.interrupt_queued);
        end
    endtask

    task automatic test_dispatch();
        bus_write(16'hFFFF, 8'h1F);
        bus_write(16'hFF0F, 8'h14);
        bus_if.write_interrupt_vector = 1'b1;
        tick();
        tests++;
        if (bus_if.int_vector !== 8'h50) begin
            fails++;
            $display("FAIL disp_vec: got %h want 50", bus_if.int_vector);
        end
        bus_if.clear_interrupt_flag = 1'b1;
        tick();
        tests++;
        if (if_reg !== 5'b10000 || ime !== 1'b0 || bus_if.interrupt_queued !== 1'b0) begin
            fails++;
            $display("FAIL disp_ack: if=%h ime=%b q=%b want 10/0/0", if_reg, ime, bus_if.interrupt_queued);
        end
        tests++;
        if (bus_if.int_vector !== 8'h50) begin
            fails++;
            $display("FAIL disp_hold: got %h want 50", bus_if.int_vector);
        end
    endtask

    task automatic test_ghost();
        bus_if.write_interrupt_vector = 1'b1;
        tick();
        tests++;
        if (bus_if.int_vector !== 8'h60) begin
            fails++;
            $display("FAIL ghost_pre: got %h want 60", bus_if.int_vector);
        end
        bus_write(16'hFFFF, 8'h00);
        bus_if.write_interrupt_vector = 1'b1;
        tick();
        tests++;
        if (bus_if.int_vector !== 8'h00 || halt_wake !== 1'b0) begin
            fails++;
            $display("FAIL ghost_vec: vec=%h wake=%b want 00/0", bus_if.int_vector, halt_wake);
        end
        bus_if.clear_interrupt_flag = 1'b1;
        tick();
        tests++;
        if (if_reg !== 5'b10000) begin
            fails++;
            $display("FAIL ghost_if: got %h want 10", if_reg);
        end
    endtask

    task automatic test_set_beats_clear();
        bus_write(16'hFFFF, 8'h04);
        bus_write(16'hFF0F, 8'h04);
        bus_if.write_interrupt_vector = 1'b1;
        tick();
        irq_req = 5'b00100;
        bus_if.wr_en = 1'b1;
        bus_if.wr_addr = 16'hFF0F;
        bus_if.wr_data = 8'h00;
        bus_if.clear_interrupt_flag = 1'b1;
        tick();
        tests++;
        if (if_reg !== 5'b00100) begin
            fails++;
            $display("FAIL set_wins: if=%h want 04", if_reg);
        end
    endtask

    task automatic test_ime_races();
        enable_interrupts = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        disable_interrupts = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b0) begin
            fails++;
            $display("FAIL ei_then_di: ime=%b want 0", ime);
        end
        enable_interrupts = 1'b1;
        disable_interrupts = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b0) begin
            fails++;
            $display("FAIL di_ei_same: ime=%b want 0", ime);
        end
        enable_interrupts = 1'b1;
        reti_enable = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b1 || bus_if.interrupt_queued !== 1'b1) begin
            fails++;
            $display("FAIL reti_ei: ime=%b q=%b want 1/1", ime, bus_if.interrupt_queued);
        end
    endtask

    task automatic test_reset_armed();
        disable_interrupts = 1'b1;
        tick();
        enable_interrupts = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({if_reg, ie_reg, ime, halt_wake} !== 15'h0) begin
            fails++;
            $display("FAIL async_rst: if=%h ie=%h ime=%b wake=%b want 0", if_reg, ie_reg, ime, halt_wake);
        end
        tests++;
        if (bus_if.int_vector !== 8'h00 || bus_if.interrupt_queued !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_vec: vec=%h q=%b want 00/0", bus_if.int_vector, bus_if.interrupt_queued);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        last_m_cycle = 1'b1;
        tick();
        last_m_cycle = 1'b1;
        tick();
        tests++;
        if (ime !== 1'b0) begin
            fails++;
            $display("FAIL rst_disarm: ime=%b want 0", ime);
        end
    endtask

    initial begin
        test_reset();
        test_irq_set();
        test_ei_delay();
        test_dispatch();
        test_ghost();
        test_set_beats_clear();
        test_ime_races();
        test_reset_armed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
Name: gb_cpu_interrupt_ctrl

Overview:
- Responder side of the CPU interrupt-dispatch handshake.
- Holds the IF and IE registers and the IME state machine, including the EI delay.
- Drives interrupt_queued into the CPU scheduler and consumes the scheduler's write_interrupt_vector / clear_interrupt_flag controls to run a dispatch.
- Also supplies the HALT wake signal and IF/IE bus reads and writes.

Parameters:
IF_ADDR, 16'hFF0F, bus address of IF
IE_ADDR, 16'hFFFF, bus address of IE
NUM_IRQ, 5, interrupt sources (bit0 VBlank … bit4 Joypad); fixed 5 for GB

Ports:
clk  in  1  machine (M) clock
reset  in  1  asynchronous, active-low reset
irq_req  in  NUM_IRQ  peripheral request pulses; high in a cycle sets the IF bit
wr_en  in  1  bus write strobe
wr_addr  in  16  bus write address
wr_data  in  8  bus write data
rd_addr  in  16  bus read address
rd_data  out  8  read data, combinational
rd_hit  out  1  rd_addr matches IF_ADDR or IE_ADDR
last_m_cycle  in  1  current M-cycle is the last of the instruction
enable_interrupts  in  1  EI executed (delayed enable)
reti_enable  in  1  RETI executed (immediate enable)
disable_interrupts  in  1  DI executed
write_interrupt_vector  in  1  dispatch vector-select cycle
clear_interrupt_flag  in  1  dispatch acknowledge cycle
interrupt_queued  out  1  dispatch request to scheduler
int_vector  out  8  latched ISR low address byte (high byte 0x00)
ime  out  1  interrupt master enable
halt_wake  out  1  any enabled interrupt pending, independent of IME
if_reg  out  5  IF contents
ie_reg  out  8  IE contents

Behaviour:
- Reset (reset=0, async): IF=0, IE=0, IME state=OFF, ime=0, int_vector=8'h00, dispatch index=0, idx_valid=0.
- pending = if_reg & ie_reg[4:0]. Priority: lowest set bit wins.
- IF update, per posedge:
  - next_IF = (wr_en && wr_addr==IF_ADDR) ? wr_data[4:0] : IF.
  - A clear_interrupt_flag acknowledge clears the latched bit.
  - OR with irq_req last, so a set always beats a write or clear in the same cycle.
- IE: all 8 bits written on wr_en && wr_addr==IE_ADDR.
- Reads:
  - rd_addr==IF_ADDR → {3'b111, IF}.
  - rd_addr==IE_ADDR → IE.
  - Otherwise 8'hFF with rd_hit=0.
  - A read in the same cycle as a write returns the old value.
- IME FSM, states OFF, ARMED, ON; transitions at posedge, priority top to bottom:
  - disable_interrupts → OFF (cancels ARMED).
  - clear_interrupt_flag → OFF.
  - reti_enable → ON.
  - enable_interrupts → ARMED (if not already ON).
  - ARMED && last_m_cycle && enable_interrupts==0 → ON, i.e. IME takes effect after the instruction following EI completes.
  - ime = (state==ON).
- interrupt_queued = ime && |pending:
  - Combinational from registered state only, with no input-to-output paths.
  - Stays stable through an M-cycle.
- Dispatch:
  - Edge with write_interrupt_vector=1: latch idx = priority(pending) and set idx_valid=|pending.
  - int_vector = idx_valid ? 8'h40 + (idx<<3) : 8'h00. pending==0 here (IE changed during the push) is a ghost dispatch to 0x0000.
  - Edge with clear_interrupt_flag=1: if idx_valid, clear IF[idx] and then clear idx_valid; force IME OFF.
  - int_vector holds its value until the next write_interrupt_vector.
- halt_wake = |pending, combinational, ignores IME.
- Simultaneous DI and EI: DI wins. Simultaneous EI and RETI: RETI wins (ON).
- A mid-dispatch reset returns everything to reset values immediately; no partial IF clear.

Test Plan:
- Reset release; IE=8'h01 written; irq_req=5'b00001 pulse → IF=5'h01, halt_wake=1, interrupt_queued=0 (IME OFF), rd_data@FF0F=8'hE1.
- EI (enable_interrupts one cycle) then a 1-cycle instruction with last_m_cycle=1 → ime rises at the edge after the second last_m_cycle, not the EI edge; interrupt_queued=1 from then.
- IE=8'h1F, IF=5'b10100, IME ON; write_interrupt_vector then clear_interrupt_flag → int_vector=8'h50, IF=5'b10000, ime=0, interrupt_queued=0.
- Latch a pending bit with write_interrupt_vector, then write IE=8'h00 before the latch edge of a new dispatch with no pending → int_vector=8'h00, clear_interrupt_flag leaves IF unchanged.
- irq_req[2] in the same cycle as a wr_en write of IF=0 and a clear of bit 2 → IF[2]=1 afterwards.
- EI followed immediately by DI → ime stays 0; assert reset low mid-ARMED → state OFF asynchronously, all outputs at reset values.
